// File: rtl/mmio_responder_pkg.sv
// Shared miniRV definitions for the data-memory responder: the IO window,
// the peripheral register offsets and the 7-segment character codes.
package mmio_responder_pkg;

  // Upper 20 address bits that select the peripheral window.
  localparam logic [19:0] IO_BASE = 20'hFFFFF;

  // Word offsets inside the IO window.
  localparam logic [11:0] ADDR_DISP = 12'h000;
  localparam logic [11:0] ADDR_TVAL = 12'h020;
  localparam logic [11:0] ADDR_TDIV = 12'h024;
  localparam logic [11:0] ADDR_LED  = 12'h060;
  localparam logic [11:0] ADDR_SW   = 12'h070;

  // Active-low segment codes {dp,g,f,e,d,c,b,a}, decimal point off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Which peripheral register an IO access targets.
  typedef enum logic [2:0] {
    REG_NONE = 3'd0,
    REG_DISP = 3'd1,
    REG_TVAL = 3'd2,
    REG_TDIV = 3'd3,
    REG_LED  = 3'd4,
    REG_SW   = 3'd5
  } reg_sel_e;

  // Map the low 12 address bits to a register; the byte lane bits are dropped.
  function automatic reg_sel_e decode_reg(input logic [11:0] offset);
    logic [11:0] word_off;
    word_off = {offset[11:2], 2'b00};
    case (word_off)
      ADDR_DISP: decode_reg = REG_DISP;
      ADDR_TVAL: decode_reg = REG_TVAL;
      ADDR_TDIV: decode_reg = REG_TDIV;
      ADDR_LED:  decode_reg = REG_LED;
      ADDR_SW:   decode_reg = REG_SW;
      default:   decode_reg = REG_NONE;
    endcase
  endfunction

  // Hex nibble to active-low segment pattern.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0:    hex_to_seg = SEG_0;
      4'h1:    hex_to_seg = SEG_1;
      4'h2:    hex_to_seg = SEG_2;
      4'h3:    hex_to_seg = SEG_3;
      4'h4:    hex_to_seg = SEG_4;
      4'h5:    hex_to_seg = SEG_5;
      4'h6:    hex_to_seg = SEG_6;
      4'h7:    hex_to_seg = SEG_7;
      4'h8:    hex_to_seg = SEG_8;
      4'h9:    hex_to_seg = SEG_9;
      4'hA:    hex_to_seg = SEG_A;
      4'hB:    hex_to_seg = SEG_B;
      4'hC:    hex_to_seg = SEG_C;
      4'hD:    hex_to_seg = SEG_D;
      4'hE:    hex_to_seg = SEG_E;
      4'hF:    hex_to_seg = SEG_F;
      default: hex_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Core data-memory port plus the pass-through data RAM port.
// The slave side is the responder; the master side is the core together
// with the RAM it fronts.
interface mmio_responder_if;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  bus_we, bus_addr, bus_wdata, ram_rdata,
    output bus_rdata, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output bus_we, bus_addr, bus_wdata, ram_rdata,
    input  bus_rdata, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mmio_responder_seg_scan.sv
// Multiplexed 8-digit 7-segment scanner. Each digit is lit for SCAN_DIV
// cycles; enables and segments are registered so the pins never glitch.
module mmio_responder_seg_scan
  import mmio_responder_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disp_i,
  output logic [7:0]  seg_en_o,
  output logic [7:0]  seg_cx_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_en_q, seg_en_d;
  logic [7:0]       seg_cx_q, seg_cx_d;

  // Dwell counter, digit index and the pin patterns for the current digit.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    seg_en_d = ~(8'd1 << idx_q);
    seg_cx_d = hex_to_seg(disp_i[{idx_q, 2'b00} +: 4]);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
  end

  // Scan state and registered display pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      seg_en_q <= 8'hFE;
      seg_cx_q <= SEG_0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_en_q <= seg_en_d;
      seg_cx_q <= seg_cx_d;
    end
  end

  assign seg_en_o = seg_en_q;
  assign seg_cx_o = seg_cx_q;

endmodule

// File: rtl/mmio_responder.sv
// miniRV data-memory responder: splits core loads/stores between the data
// RAM and the peripheral registers (display, timer, LEDs, switches).
// Reads are combinational because the core completes a load in one cycle.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mmio_responder_if.slave     bus,
  input  logic [23:0]         sw,
  output logic [23:0]         led,
  output logic [7:0]          seg_en,
  output logic [7:0]          seg_cx
);

  logic        io_s;
  logic        wr_s;
  reg_sel_e    sel_s;
  logic        tick_s;
  logic [31:0] rdata_s;

  logic [31:0] disp_q, disp_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] tdiv_q, tdiv_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [23:0] led_q,  led_d;
  logic [23:0] sync_q [SYNC_STAGES];

  assign io_s  = (bus.bus_addr[31:12] == IO_BASE);
  assign sel_s = io_s ? decode_reg(bus.bus_addr[11:0]) : REG_NONE;
  assign wr_s  = bus.bus_we & io_s;

  // The prescaler completes a period when it reaches TDIV-1; TDIV of zero
  // never ticks.
  assign tick_s = (tdiv_q != 32'd0) && (pcnt_q == (tdiv_q - 32'd1));

  // RAM side is a straight pass-through, with stores suppressed in IO space.
  assign bus.ram_we    = bus.bus_we & ~io_s;
  assign bus.ram_addr  = bus.bus_addr[15:2];
  assign bus.ram_wdata = bus.bus_wdata;
  assign bus.bus_rdata = rdata_s;

  // Load data mux: RAM for normal space, register file for the IO window.
  always_comb begin
    rdata_s = 32'd0;
    if (io_s) begin
      case (sel_s)
        REG_DISP: rdata_s = disp_q;
        REG_TVAL: rdata_s = tval_q;
        REG_TDIV: rdata_s = tdiv_q;
        REG_LED:  rdata_s = {8'd0, led_q};
        REG_SW:   rdata_s = {8'd0, sync_q[SYNC_STAGES-1]};
        default:  rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = bus.ram_rdata;
    end
  end

  // Next register state: timer advance first, then a store overrides it so
  // a written TVAL beats a coincident tick and a TDIV write restarts pcnt.
  always_comb begin
    disp_d = disp_q;
    tval_d = tval_q;
    tdiv_d = tdiv_q;
    pcnt_d = pcnt_q;
    led_d  = led_q;
    if (tdiv_q == 32'd0) begin
      pcnt_d = 32'd0;
    end else if (tick_s) begin
      pcnt_d = 32'd0;
    end else begin
      pcnt_d = pcnt_q + 32'd1;
    end
    if (tick_s) begin
      tval_d = tval_q + 32'd1;
    end else begin
      tval_d = tval_q;
    end
    if (wr_s) begin
      case (sel_s)
        REG_DISP: disp_d = bus.bus_wdata;
        REG_TVAL: tval_d = bus.bus_wdata;
        REG_TDIV: begin
          tdiv_d = bus.bus_wdata;
          pcnt_d = 32'd0;
        end
        REG_LED:  led_d  = bus.bus_wdata[23:0];
        default:  begin end
      endcase
    end else begin
      disp_d = disp_d;
    end
  end

  // Peripheral register file and timer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= 32'd0;
      tval_q <= 32'd0;
      tdiv_q <= 32'd0;
      pcnt_q <= 32'd0;
      led_q  <= 24'd0;
    end else begin
      disp_q <= disp_d;
      tval_q <= tval_d;
      tdiv_q <= tdiv_d;
      pcnt_q <= pcnt_d;
      led_q  <= led_d;
    end
  end

  // Switch synchronizer; the switches are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 24'd0;
      end
    end else begin
      sync_q[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign led = led_q;

  mmio_responder_seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .disp_i   (disp_q),
    .seg_en_o (seg_en),
    .seg_cx_o (seg_cx)
  );

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus random
// traffic, with expectations from a behavioural model queued for a monitor.
module tb_mmio_responder;

  localparam int SCAN_DIV = 4;
  localparam int SYNC     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  seg_en;
  logic [7:0]  seg_cx;

  mmio_responder_if bus_if ();

  mmio_responder #(.SCAN_DIV(SCAN_DIV), .SYNC_STAGES(SYNC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_if.slave),
    .sw     (sw),
    .led    (led),
    .seg_en (seg_en),
    .seg_cx (seg_cx)
  );

  always #5 clk = ~clk;

  typedef enum int {K_RDATA, K_RAMWE, K_RAMADDR, K_RAMWDATA, K_LED, K_SEGEN, K_SEGCX} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state
  logic [31:0] m_disp, m_tval, m_tdiv, m_pcnt;
  logic [23:0] m_led;
  logic [23:0] m_sw_hist[$];
  int          m_edges;
  logic [7:0]  m_seg_en, m_seg_cx;

  task automatic push(input kind_e k, input logic [31:0] v, input string tag);
    exp_t e;
    e.kind = k; e.exp = v; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic model_reset();
    m_disp = 32'd0; m_tval = 32'd0; m_tdiv = 32'd0; m_pcnt = 32'd0;
    m_led = 24'd0; m_edges = 0; m_seg_en = 8'hFE; m_seg_cx = 8'hC0;
    m_sw_hist.delete();
    for (int i = 0; i < SYNC; i++) m_sw_hist.push_back(24'd0);
  endtask

  // Expected values for the inputs currently applied, from model state.
  task automatic push_model();
    logic [31:0] a;
    logic        io;
    logic [11:0] off;
    logic [31:0] rd;
    a   = bus_if.bus_addr;
    io  = (a[31:12] == 20'hFFFFF);
    off = {a[11:2], 2'b00};
    if (!io) rd = bus_if.ram_rdata;
    else if (off == 12'h000) rd = m_disp;
    else if (off == 12'h020) rd = m_tval;
    else if (off == 12'h024) rd = m_tdiv;
    else if (off == 12'h060) rd = {8'd0, m_led};
    else if (off == 12'h070) rd = {8'd0, m_sw_hist[SYNC-1]};
    else rd = 32'd0;
    push(K_RDATA,    rd, $sformatf("rdata@%h", a));
    push(K_RAMWE,    {31'd0, bus_if.bus_we & ~io}, $sformatf("ram_we@%h", a));
    push(K_RAMADDR,  {18'd0, a[15:2]}, "ram_addr");
    push(K_RAMWDATA, bus_if.bus_wdata, "ram_wdata");
    push(K_LED,      {8'd0, m_led}, "led");
    push(K_SEGEN,    {24'd0, m_seg_en}, "seg_en");
    push(K_SEGCX,    {24'd0, m_seg_cx}, "seg_cx");
  endtask

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic model_step();
    logic        io, wr, tick;
    logic [11:0] off;
    logic [31:0] wd;
    int          digit;
    if (!rst_n) return;
    io   = (bus_if.bus_addr[31:12] == 20'hFFFFF);
    off  = {bus_if.bus_addr[11:2], 2'b00};
    wr   = bus_if.bus_we && io;
    wd   = bus_if.bus_wdata;
    // display pins show the digit selected before this edge
    digit    = (m_edges / SCAN_DIV) % 8;
    m_seg_en = ~(8'd1 << digit);
    m_seg_cx = hex_tab[(m_disp >> (4 * digit)) & 32'hF];
    m_edges++;
    // timer: a period ends once TDIV cycles have elapsed
    tick = (m_tdiv != 32'd0) && (({1'b0, m_pcnt} + 33'd1) == {1'b0, m_tdiv});
    if (wr && off == 12'h024) m_pcnt = 32'd0;
    else if (m_tdiv == 32'd0 || tick) m_pcnt = 32'd0;
    else m_pcnt = m_pcnt + 32'd1;
    if (wr && off == 12'h020) m_tval = wd;
    else if (tick) m_tval = m_tval + 32'd1;
    if (wr && off == 12'h024) m_tdiv = wd;
    if (wr && off == 12'h000) m_disp = wd;
    if (wr && off == 12'h060) m_led = wd[23:0];
    m_sw_hist.push_front(sw);
    void'(m_sw_hist.pop_back());
  endtask

  task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wd;
    bus_if.ram_rdata = $urandom;
    push_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: every queued expectation is checked away from the active edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_RDATA:    act = bus_if.bus_rdata;
        K_RAMWE:    act = {31'd0, bus_if.ram_we};
        K_RAMADDR:  act = {18'd0, bus_if.ram_addr};
        K_RAMWDATA: act = bus_if.ram_wdata;
        K_LED:      act = {8'd0, led};
        K_SEGEN:    act = {24'd0, seg_en};
        default:    act = {24'd0, seg_cx};
      endcase
      tests_run++;
      if (act !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h at %0t", e.tag, act, e.exp, $time);
      end
    end
  end

  logic [31:0] io_addrs [6] = '{32'hFFFFF000, 32'hFFFFF020, 32'hFFFFF024,
                                32'hFFFFF060, 32'hFFFFF070, 32'hFFFFF100};

  initial begin
    logic [31:0] a, d;
    logic        we;
    rst_n = 1'b0;
    sw    = 24'd0;
    model_reset();

    // Reset state, observed while rst_n is still low
    push(K_RDATA, 32'd0, "rst_led_rd"); push(K_LED, 32'd0, "rst_led");
    push(K_SEGEN, 32'hFE, "rst_seg_en"); push(K_SEGCX, 32'hC0, "rst_seg_cx");
    cyc(1'b0, 32'hFFFFF060, 32'd0);
    rst_n = 1'b1;
    push(K_RDATA, 32'd0, "rd_led0");  cyc(1'b0, 32'hFFFFF060, 32'd0);
    push(K_RDATA, 32'd0, "rd_disp0"); cyc(1'b0, 32'hFFFFF000, 32'd0);
    push(K_RDATA, 32'd0, "rd_tval0"); cyc(1'b0, 32'hFFFFF020, 32'd0);

    // LED store, then RAM store
    push(K_RAMWE, 32'd0, "led_st_ramwe"); cyc(1'b1, 32'hFFFFF060, 32'h00ABCDEF);
    push(K_LED, 32'h00ABCDEF, "led_pins"); push(K_RDATA, 32'h00ABCDEF, "led_rd");
    cyc(1'b0, 32'hFFFFF060, 32'd0);
    push(K_RAMWE, 32'd1, "ram_st_we"); push(K_RAMADDR, 32'd4, "ram_st_addr");
    push(K_RAMWDATA, 32'h12345678, "ram_st_wdata");
    cyc(1'b1, 32'h00000010, 32'h12345678);

    // Switch synchronizer latency and read-only SW register
    sw = 24'h5A5A5A;
    push(K_RDATA, 32'd0, "sw_lat0"); cyc(1'b0, 32'hFFFFF070, 32'd0);
    push(K_RDATA, 32'd0, "sw_lat1"); cyc(1'b0, 32'hFFFFF070, 32'd0);
    push(K_RDATA, 32'h005A5A5A, "sw_lat2"); cyc(1'b1, 32'hFFFFF070, 32'hFFFFFFFF);
    push(K_RDATA, 32'h005A5A5A, "sw_ro");   cyc(1'b0, 32'hFFFFF070, 32'd0);

    // Timer wrap with TDIV=3
    cyc(1'b1, 32'hFFFFF020, 32'hFFFFFFFE);
    cyc(1'b1, 32'hFFFFF024, 32'd3);
    for (int r = 1; r <= 7; r++) begin
      if (r == 1) push(K_RDATA, 32'hFFFFFFFE, "tmr_r1");
      if (r == 4) push(K_RDATA, 32'hFFFFFFFF, "tmr_r4");
      if (r == 7) push(K_RDATA, 32'h00000000, "tmr_wrap");
      cyc(1'b0, 32'hFFFFF020, 32'd0);
    end
    cyc(1'b1, 32'hFFFFF024, 32'd0);
    for (int r = 0; r < 5; r++) begin
      push(K_RDATA, 32'd0, "tmr_frozen");
      cyc(1'b0, 32'hFFFFF020, 32'd0);
    end
    // TVAL write on a tick edge
    cyc(1'b1, 32'hFFFFF024, 32'd2);
    cyc(1'b0, 32'hFFFFF020, 32'd0);
    cyc(1'b1, 32'hFFFFF020, 32'h00000055);
    push(K_RDATA, 32'h55, "tick_wr0"); cyc(1'b0, 32'hFFFFF020, 32'd0);
    push(K_RDATA, 32'h55, "tick_wr1"); cyc(1'b0, 32'hFFFFF020, 32'd0);
    push(K_RDATA, 32'h56, "tick_wr2"); cyc(1'b0, 32'hFFFFF020, 32'd0);
    cyc(1'b1, 32'hFFFFF024, 32'd0);

    // Asynchronous reset mid-operation, no clock edge needed
    rst_n = 1'b0;
    model_reset();
    push(K_LED, 32'd0, "arst_led"); push(K_SEGEN, 32'hFE, "arst_seg_en");
    push(K_RDATA, 32'd0, "arst_tval");
    cyc(1'b0, 32'hFFFFF020, 32'd0);
    rst_n = 1'b1;

    // Display scan with a freshly reset scan counter
    for (int n = 0; n <= 40; n++) begin
      case (n)
        2:  begin push(K_SEGEN, 32'hFE, "scan_en0"); push(K_SEGCX, 32'hC0, "scan_d0"); end
        5:  begin push(K_SEGEN, 32'hFD, "scan_en1"); push(K_SEGCX, 32'h8E, "scan_d1"); end
        9:  begin push(K_SEGEN, 32'hFB, "scan_en2"); push(K_SEGCX, 32'hF9, "scan_d2"); end
        13: begin push(K_SEGEN, 32'hF7, "scan_en3"); push(K_SEGCX, 32'h88, "scan_d3"); end
        29: begin push(K_SEGEN, 32'h7F, "scan_en7"); push(K_SEGCX, 32'hC0, "scan_d7"); end
        33: begin push(K_SEGEN, 32'hFE, "scan_wrap"); end
        default: begin end
      endcase
      if (n == 0) cyc(1'b1, 32'hFFFFF000, 32'h0000A1F0);
      else cyc(1'b0, 32'h00000100, 32'd0);
    end

    // Unmapped IO offset
    push(K_RDATA, 32'd0, "unmap_rd"); cyc(1'b0, 32'hFFFFF100, 32'd0);
    push(K_RAMWE, 32'd0, "unmap_ramwe"); cyc(1'b1, 32'hFFFFF100, 32'hFFFFFFFF);
    push(K_RDATA, 32'h0000A1F0, "unmap_disp"); cyc(1'b0, 32'hFFFFF000, 32'd0);
    cyc(1'b0, 32'hFFFFF060, 32'd0);
    cyc(1'b0, 32'hFFFFF024, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a = $urandom & 32'h0000FFFF;
      else a = io_addrs[$urandom_range(0, 5)] | {30'd0, 2'($urandom)};
      we = 1'($urandom);
      d  = $urandom;
      if ({a[31:2], 2'b00} == 32'hFFFFF024) d = $urandom_range(0, 5);
      cyc(we, a, d);
    end

    @(negedge clk);
    #1;
    tests_run++;
    if (sbq.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
